// File: rtl/booth_divider.sv
`default_nettype none
// ---------------------------------------------------------------------------
// booth_divider : sequential signed restoring divider, {remainder, quotient}
// Revision      : 1.0
// ---------------------------------------------------------------------------
module booth_divider #(
  parameter int N     = 8,
  parameter int alpha = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   data_inQ,
  input  logic [N-1:0]   data_inM,
  output logic [2*N-1:0] ans,
  output logic           done,
  output logic           busy,
  output logic           dz,
  output logic           ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } state_t;

  localparam logic [alpha:0] CNT_INIT = (alpha+1)'(N);
  localparam logic [alpha:0] CNT_ONE  = (alpha+1)'(1);
  localparam logic [N-1:0]   MOST_NEG = {1'b1, {(N-1){1'b0}}};

  state_t           state_q, state_d;
  logic [N-1:0]     q_q, q_d;
  logic [N-1:0]     m_q, m_d;
  logic [N:0]       a_q, a_d;
  logic [alpha:0]   cnt_q, cnt_d;
  logic             sq_q, sq_d;
  logic             sm_q, sm_d;
  logic             ovfp_q, ovfp_d;
  logic [2*N-1:0]   ans_q, ans_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;

  logic [N:0]       a_sh;
  logic [N:0]       trial;
  logic [N-1:0]     quot;
  logic [N-1:0]     rem;

  // Restoring step: shift the next dividend bit into A and trial-subtract |M|.
  assign a_sh  = {a_q[N-1:0], q_q[N-1]};
  assign trial = a_sh - {1'b0, m_q};
  assign quot  = (sq_q ^ sm_q) ? -q_q : q_q;
  assign rem   = sq_q ? -a_q[N-1:0] : a_q[N-1:0];

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    m_d     = m_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    sq_d    = sq_q;
    sm_d    = sm_q;
    ovfp_d  = ovfp_q;
    ans_d   = ans_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          q_d     = data_inQ;
          m_d     = data_inM;
          state_d = LOAD;
        end
      end
      LOAD: begin
        sq_d   = q_q[N-1];
        sm_d   = m_q[N-1];
        q_d    = q_q[N-1] ? -q_q : q_q;
        m_d    = m_q[N-1] ? -m_q : m_q;
        a_d    = '0;
        cnt_d  = CNT_INIT;
        ovfp_d = (q_q == MOST_NEG) && (m_q == {N{1'b1}});
        if (m_q == '0) begin
          ans_d   = {q_q, {N{1'b1}}};
          dz_d    = 1'b1;
          ovf_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = ITER;
        end
      end
      ITER: begin
        if (!trial[N]) begin
          a_d = trial;
          q_d = {q_q[N-2:0], 1'b1};
        end else begin
          a_d = a_sh;
          q_d = {q_q[N-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = FIX;
      end
      FIX: begin
        ans_d   = {rem, quot};
        dz_d    = 1'b0;
        ovf_d   = ovfp_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= '0;
      m_q     <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
      sq_q    <= 1'b0;
      sm_q    <= 1'b0;
      ovfp_q  <= 1'b0;
      ans_q   <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      m_q     <= m_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      sq_q    <= sq_d;
      sm_q    <= sm_d;
      ovfp_q  <= ovfp_d;
      ans_q   <= ans_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ans  = ans_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);
  assign dz   = dz_q;
  assign ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_divider.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_booth_divider : scoreboard bench for booth_divider, directed vectors
// Revision         : 1.0
// ---------------------------------------------------------------------------
module tb_booth_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  data_inQ;
  logic [7:0]  data_inM;
  logic [15:0] ans;
  logic        done;
  logic        busy;
  logic        dz;
  logic        ovf;

  typedef struct packed {
    logic [15:0] ans;
    logic        dz;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  booth_divider #(.N(8), .alpha(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .data_inQ (data_inQ),
    .data_inM (data_inM),
    .ans      (ans),
    .done     (done),
    .busy     (busy),
    .dz       (dz),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] a, input logic d, input logic o);
    exp_t e;
    e.ans = a;
    e.dz  = d;
    e.ovf = o;
    return e;
  endfunction

  // Monitor: every completion pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ans", {16'd0, ans}, {16'd0, e.ans});
        chk("dz",  {31'd0, dz},  {31'd0, e.dz});
        chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
      end
    end
  end

  task automatic run_op(input logic [7:0] qv, input logic [7:0] mv,
                        input exp_t e, input int lat);
    int n;
    @(negedge clk);
    data_inQ = qv;
    data_inM = mv;
    start    = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    start    = 1'b0;
    data_inQ = ~qv;
    data_inM = 8'h03;
    if (lat > 1) chk("busy_after_start", {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, lat);
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n;
    int k;
    int last;
    int guard;
    rst_n    = 1'b0;
    start    = 1'b0;
    data_inQ = 8'h00;
    data_inM = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ans",  {16'd0, ans},  32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_dz",   {31'd0, dz},   32'd0);
    chk("rst_ovf",  {31'd0, ovf},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h64, 8'h07, mk(16'h020E, 1'b0, 1'b0), 10);
    run_op(8'h9C, 8'h07, mk(16'hFEF2, 1'b0, 1'b0), 10);
    run_op(8'h64, 8'hF9, mk(16'h02F2, 1'b0, 1'b0), 10);
    run_op(8'h9C, 8'hF9, mk(16'hFE0E, 1'b0, 1'b0), 10);
    run_op(8'h80, 8'hFF, mk(16'h0080, 1'b0, 1'b1), 10);
    run_op(8'h80, 8'h01, mk(16'h0080, 1'b0, 1'b0), 10);
    run_op(8'h25, 8'h00, mk(16'h25FF, 1'b1, 1'b0), 1);
    run_op(8'h7F, 8'h0A, mk(16'h070C, 1'b0, 1'b0), 10);

    // Start pulse while busy must be dropped; original operands must finish.
    @(negedge clk);
    data_inQ = 8'h64;
    data_inM = 8'h07;
    start    = 1'b1;
    sb.push_back(mk(16'h020E, 1'b0, 1'b0));
    @(posedge clk); #1;
    start    = 1'b0;
    data_inQ = 8'h11;
    data_inM = 8'h22;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 4;
    while (!done && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("busy_start_latency", n, 10);
    repeat (15) @(posedge clk);
    #1;
    chk("busy_start_drained", sb.size(), 0);

    // Start held high: completions every N+3 cycles.
    @(negedge clk);
    data_inQ = 8'h64;
    data_inM = 8'h07;
    start    = 1'b1;
    repeat (3) sb.push_back(mk(16'h020E, 1'b0, 1'b0));
    k = 0;
    last = 0;
    guard = 0;
    while (k < 3 && guard < 60) begin
      @(posedge clk); #1;
      guard++;
      if (done) begin
        if (k > 0) chk("held_start_interval", cyc - last, 11);
        last = cyc;
        k++;
        if (k == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    chk("held_start_count", k, 3);
    repeat (14) @(posedge clk);
    #1;
    chk("held_start_drained", sb.size(), 0);

    // Asynchronous reset mid-iteration clears everything at once.
    @(negedge clk);
    data_inQ = 8'h9C;
    data_inM = 8'h07;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ans",  {16'd0, ans},  32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_dz",   {31'd0, dz},   32'd0);
    chk("midrst_ovf",  {31'd0, ovf},  32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("no_partial_after_reset", {16'd0, ans}, 32'd0);
    run_op(8'h32, 8'h05, mk(16'h000A, 1'b0, 1'b0), 10);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
